// File: rtl/capture_readout_if.sv
// Storage/host-facing bus of the capture readout block.
// master = readout engine, slave = storage + host side.
interface capture_readout_if;
   logic        start;
   logic        _ffa;
   logic [15:0] din;
   logic        cap_rst;
   logic        load;
   logic [2:0]  cntrl_bits;
   logic        rden;
   logic [7:0]  bdata;
   logic        bvalid;
   logic        bready;
   logic        busy;
   logic        done;

   modport master (
      input  start, _ffa, din, bready,
      output cap_rst, load, cntrl_bits, rden, bdata, bvalid, busy, done
   );
   modport slave (
      output start, _ffa, din, bready,
      input  cap_rst, load, cntrl_bits, rden, bdata, bvalid, busy, done
   );
endinterface

// File: rtl/capture_readout.sv
// Octal capture readout: arm, wait for full, read ch0..7 through a credit-controlled skid FIFO, emit bytes MSB first.
// Optional per-channel header (8'hA5, channel) is enabled by defining CAPTURE_READOUT_HEADER_EN.
module capture_readout #(
   parameter int WORDS      = 8191,
   parameter int RD_LAT     = 2,
   parameter int SWITCH_GAP = 3,
   parameter int BUF_DEPTH  = 4
)(
   input logic              rdclk,
   input logic              _rst,
   capture_readout_if.master bus
);
   localparam int WCW = $clog2(WORDS + 1);
   localparam int AW  = $clog2(BUF_DEPTH);
   localparam int CW  = $clog2(BUF_DEPTH + 1);
   localparam int GW  = $clog2(SWITCH_GAP + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLR   = 3'd1;
   localparam logic [2:0] S_ARM   = 3'd2;
   localparam logic [2:0] S_SEL   = 3'd3;
   localparam logic [2:0] S_READ  = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;
   localparam logic [2:0] S_FIN   = 3'd6;

   logic [2:0]        state_q, state_d;
   logic              clr_q, clr_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [WCW-1:0]    wcnt_q, wcnt_d;
   logic [2:0]        cntrl_q, cntrl_d;
   logic              rden_q, rden_d;
   logic              done_q, done_d;
   logic [RD_LAT-1:0] pipe_q, pipe_d;

   logic [15:0]       mem [BUF_DEPTH];
   logic [AW-1:0]     wp_q, rp_q;
   logic [CW-1:0]     cnt_q;
   logic [15:0]       word_q;
   logic              lo_q, bv_q;

   logic              fire, can_load, pop, push, gap_done, hdr_load, hdr_ok;
   logic [15:0]       occ;

   assign fire     = bv_q & bus.bready;
   assign can_load = ~bv_q | (fire & lo_q);
   assign pop      = can_load & (cnt_q != '0);
   assign push     = pipe_q[RD_LAT-1];
   assign gap_done = (gap_q == GW'(SWITCH_GAP - 1));
   assign pipe_d   = RD_LAT'({pipe_q, rden_q});

`ifdef CAPTURE_READOUT_HEADER_EN
   // 0: header not sent, 1: header in serialiser, 2: header fully accepted
   logic [1:0] hdr_q;
   assign hdr_load = (state_q == S_SEL) & (hdr_q == 2'd0) & can_load & (cnt_q == '0);
   assign hdr_ok   = (hdr_q == 2'd2);

   always_ff @(posedge rdclk or negedge _rst) begin
      if (!_rst)                          hdr_q <= 2'd0;
      else if (state_q != S_SEL)          hdr_q <= 2'd0;
      else if (hdr_load)                  hdr_q <= 2'd1;
      else if (hdr_q == 2'd1 && fire && lo_q) hdr_q <= 2'd2;
   end
`else
   assign hdr_load = 1'b0;
   assign hdr_ok   = 1'b1;
`endif

   // Credit: words in the FIFO plus words requested but not yet landed.
   always_comb begin
      occ = 16'(cnt_q) + 16'(rden_q);
      for (int i = 0; i < RD_LAT; i++) occ = occ + 16'(pipe_q[i]);
   end

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      gap_d   = '0;
      wcnt_d  = wcnt_q;
      cntrl_d = cntrl_q;
      rden_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            clr_d = 1'b0;
            if (bus.start) state_d = S_CLR;
         end
         S_CLR: begin
            if (clr_q) state_d = S_ARM;
            else       clr_d   = 1'b1;
         end
         S_ARM: begin
            if (!bus._ffa) begin
               cntrl_d = 3'd0;
               state_d = S_SEL;
            end
         end
         S_SEL: begin
            wcnt_d = '0;
            gap_d  = gap_done ? gap_q : gap_q + GW'(1);
            if (gap_done && hdr_ok) state_d = S_READ;
         end
         S_READ: begin
            if (wcnt_q < WCW'(WORDS) && occ < 16'(BUF_DEPTH)) begin
               rden_d = 1'b1;
               wcnt_d = wcnt_q + WCW'(1);
               if (wcnt_q == WCW'(WORDS - 1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!rden_q && pipe_q == '0 && cnt_q == '0) begin
               if (cntrl_q != 3'd7) begin
                  cntrl_d = cntrl_q + 3'd1;
                  state_d = S_SEL;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_FIN: begin
            if (cnt_q == '0 && ((fire && lo_q) || !bv_q)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge rdclk or negedge _rst) begin
      if (!_rst) begin
         state_q <= S_IDLE;
         clr_q   <= 1'b0;
         gap_q   <= '0;
         wcnt_q  <= '0;
         cntrl_q <= 3'd0;
         rden_q  <= 1'b0;
         done_q  <= 1'b0;
         pipe_q  <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         gap_q   <= gap_d;
         wcnt_q  <= wcnt_d;
         cntrl_q <= cntrl_d;
         rden_q  <= rden_d;
         done_q  <= done_d;
         pipe_q  <= pipe_d;
      end
   end

   // Push lands RD_LAT cycles after rden regardless of bready; credit prevents overflow.
   always_ff @(posedge rdclk) begin
      if (push) mem[wp_q] <= bus.din;
   end

   always_ff @(posedge rdclk or negedge _rst) begin
      if (!_rst) begin
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
         word_q <= 16'h0000;
         lo_q   <= 1'b0;
         bv_q   <= 1'b0;
      end else begin
         if (push) wp_q <= wp_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: ;
         endcase
         if (pop) begin
            word_q <= mem[rp_q];
            rp_q   <= rp_q + AW'(1);
            lo_q   <= 1'b0;
            bv_q   <= 1'b1;
         end else if (hdr_load) begin
            word_q <= {8'hA5, 5'b0, cntrl_q};
            lo_q   <= 1'b0;
            bv_q   <= 1'b1;
         end else if (fire && !lo_q) begin
            lo_q <= 1'b1;
         end else if (can_load) begin
            bv_q <= 1'b0;
         end
      end
   end

   assign bus.cap_rst    = (state_q == S_CLR);
   assign bus.load       = (state_q == S_ARM);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.cntrl_bits = cntrl_q;
   assign bus.rden       = rden_q;
   assign bus.bdata      = lo_q ? word_q[7:0] : word_q[15:8];
   assign bus.bvalid     = bv_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout: storage model driving din, byte-stream reference built from channel/address rules.
module tb_capture_readout;
   localparam int TW   = 20;
   localparam int TLAT = 2;
   localparam int TGAP = 3;
   localparam int TDEP = 4;
   localparam int WDOG = 5000;
`ifdef CAPTURE_READOUT_HEADER_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   typedef struct {
      logic [7:0] b;
      bit         hdr;
   } exp_t;

   logic rdclk = 1'b0;
   logic _rst  = 1'b0;
   capture_readout_if bus();

   capture_readout #(.WORDS(TW), .RD_LAT(TLAT), .SWITCH_GAP(TGAP), .BUF_DEPTH(TDEP)) dut (
      .rdclk(rdclk),
      ._rst (_rst),
      .bus  (bus)
   );

   always #5 rdclk = ~rdclk;

   int cyc = 0;
   always @(posedge rdclk) cyc <= cyc + 1;

   int bready_pct = 100;
   always @(posedge rdclk) begin
      #2;
      bus.bready = ($urandom_range(99) < bready_pct);
   end

   int checks = 0;
   int errors = 0;

   function automatic void chk(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   // Whole stream from the readout rules: per channel optional header, then {ch,addr} words MSB first.
   function automatic void build_stream(output exp_t q[$]);
      logic [15:0] w;
      q = {};
      for (int c = 0; c < 8; c++) begin
         if (HDR) begin
            q.push_back('{8'hA5, 1'b1});
            q.push_back('{8'(c), 1'b1});
         end
         for (int a = 0; a < TW; a++) begin
            w = {3'(c), 13'(a)};
            q.push_back('{w[15:8], 1'b0});
            q.push_back('{w[7:0], 1'b0});
         end
      end
   endfunction

   int epoch = 0;

   // Monitor / storage model / scoreboard
   exp_t        exp_q[$];
   exp_t        tq[$];
   exp_t        e;
   logic [15:0] sched [int];
   int          seen_epoch = 0;
   bit          pinned = 0;
   int          addr = 0, chan_rden = 0, rden_tot = 0, data_bytes = 0, quiet = 0;
   int          cap_rise = 0, cap_cyc = 0, load_cyc = 0, done_cnt = 0, last_acc = 0, busy_run = 0;
   logic [2:0]  prev_cntrl = 3'd0;
   logic        prev_cap = 1'b0, stall = 1'b0;
   logic [7:0]  stall_b = 8'h00;

   always @(negedge rdclk) begin
      if (!pinned) begin
         pinned = 1;
         build_stream(tq);
         chk("pin_len", tq.size(), HDR ? 336 : 320);
         chk("pin_b0", tq[0].b, HDR ? 8'hA5 : 8'h00);
         chk("pin_b1", tq[1].b, 8'h00);
         chk("pin_last_hi", tq[tq.size()-2].b, 8'hE0);
         chk("pin_last_lo", tq[tq.size()-1].b, 8'h13);
         chk("pin_ch1", tq[HDR ? 42 : 40].b, HDR ? 8'hA5 : 8'h20);
         chk("pin_ch1b", tq[HDR ? 43 : 41].b, HDR ? 8'h01 : 8'h00);
      end
      if (epoch != seen_epoch) begin
         seen_epoch = epoch;
         cap_rise = 0; cap_cyc = 0; load_cyc = 0; done_cnt = 0;
      end
      if (!_rst) begin
         chk("reset_out", {bus.cap_rst, bus.load, bus.cntrl_bits, bus.rden, bus.bdata,
                           bus.bvalid, bus.busy, bus.done}, 0);
         prev_cntrl = 3'd0; quiet = 0; chan_rden = 0; stall = 1'b0; prev_cap = 1'b0; busy_run = 0;
      end else begin
         if (bus.cap_rst && !prev_cap) begin
            cap_rise++;
            build_stream(exp_q);
            sched.delete();
            addr = 0; rden_tot = 0; data_bytes = 0; chan_rden = 0;
         end
         prev_cap = bus.cap_rst;
         if (bus.cap_rst) cap_cyc++;
         if (bus.load) load_cyc++;

         if (bus.cntrl_bits != prev_cntrl) begin
            if (bus.cntrl_bits != 3'd0) begin
               chk("chan_rden", chan_rden, TW);
               chk("chan_step", bus.cntrl_bits, prev_cntrl + 1);
            end
            chan_rden = 0; addr = 0; quiet = TGAP + 1;
            prev_cntrl = bus.cntrl_bits;
         end
         if (quiet > 0) begin
            chk("gap_rden", bus.rden, 0);
            quiet--;
         end
         if (bus.rden) begin
            sched[cyc + TLAT] = {bus.cntrl_bits, 13'(addr)};
            addr++; chan_rden++; rden_tot++;
            chk("credit", (rden_tot - data_bytes / 2) <= TDEP + 1, 1);
         end
         bus.din = sched.exists(cyc) ? sched[cyc] : 16'($urandom);

         if (stall) begin
            chk("hold_valid", bus.bvalid, 1);
            chk("hold_data", bus.bdata, stall_b);
         end
         if (bus.bvalid && bus.bready) begin
            if (exp_q.size() == 0) begin
               chk("extra_byte", bus.bdata, 0);
            end else begin
               e = exp_q.pop_front();
               chk("byte", bus.bdata, e.b);
               if (!e.hdr) data_bytes++;
            end
            last_acc = cyc;
         end
         stall   = bus.bvalid && !bus.bready;
         stall_b = bus.bdata;

         if (bus.done) begin
            chk("done_once", done_cnt, 0);
            done_cnt++;
            chk("done_time", cyc, last_acc + 1);
            chk("stream_left", exp_q.size(), 0);
            chk("ch7_rden", chan_rden, TW);
            chk("last_chan", bus.cntrl_bits, 7);
            chk("cap_rise", cap_rise, 1);
            chk("cap_cyc", cap_cyc, 2);
            chk("load_cyc", load_cyc, 51);
         end

         if (bus.busy) begin
            busy_run++;
            if (busy_run == WDOG) chk("watchdog_busy", busy_run, 0);
         end else begin
            busy_run = 0;
         end
      end
   end

   task automatic pulse_start();
      @(posedge rdclk); #2 bus.start = 1'b1;
      @(posedge rdclk); #2 bus.start = 1'b0;
   endtask

   task automatic arm_run(input int pct);
      epoch++;
      bready_pct = pct;
      bus._ffa = 1'b1;
      pulse_start();
      for (int i = 0; i < 200 && !bus.load; i++) @(negedge rdclk);
      repeat (50) @(negedge rdclk);
      bus._ffa = 1'b0;
   endtask

   task automatic wait_cntrl(input logic [2:0] c);
      for (int i = 0; i < WDOG && bus.cntrl_bits != c; i++) @(negedge rdclk);
   endtask

   task automatic wait_done();
      for (int i = 0; i < WDOG + 100 && !bus.done; i++) @(negedge rdclk);
      repeat (5) @(negedge rdclk);
   endtask

   initial begin
      bus.start = 1'b0;
      bus._ffa  = 1'b1;
      repeat (4) @(negedge rdclk);
      @(posedge rdclk); #2 _rst = 1'b1;
      repeat (3) @(negedge rdclk);

      // full-rate host
      arm_run(100);
      wait_done();

      // throttled host, _ffa glitch and a start while busy
      arm_run(30);
      wait_cntrl(3'd1);
      bus._ffa = 1'b1;
      repeat (5) @(negedge rdclk);
      bus._ffa = 1'b0;
      wait_cntrl(3'd2);
      pulse_start();
      wait_done();

      // async reset in the middle of channel 3
      arm_run(60);
      for (int i = 0; i < WDOG && !(bus.cntrl_bits == 3'd3 && chan_rden >= 10); i++) @(negedge rdclk);
      @(posedge rdclk); #1 _rst = 1'b0;
      repeat (3) @(negedge rdclk);
      @(posedge rdclk); #2 _rst = 1'b1;
      repeat (3) @(negedge rdclk);

      // clean readout after the reset
      arm_run(50);
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
- Downstream consumer of the octal capture storage stage.
- Arms a capture, waits for the storage full flag, then walks channels 0..7 in order.
- Per channel: drives the channel select, issues read strobes, and buffers the returned 16-bit words in a credit-controlled 4-word skid FIFO.
- Serialises each word as two bytes, MSB first, onto a valid/ready byte stream toward the host interface.

Parameters:
- WORDS, 8191, words read per channel (storage saturates at 8191 written entries).
- RD_LAT, 2, rdclk cycles from rden high to the corresponding word valid on din.
- SWITCH_GAP, 3, idle cycles after a cntrl_bits change before the first rden (covers the storage read-address reset).
- BUF_DEPTH, 4, skid FIFO depth in words; power of two, minimum 2.

Ports:
- rdclk  in  1  sole clock; storage read clock, all logic on posedge.
- _rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins arm + readout; ignored unless IDLE.
- _ffa  in  1  storage full flag, active-low (0 = capture complete).
- din  in  16  storage dout.
- cap_rst  out  1  active-high reset pulse to storage (clears write address).
- load  out  1  storage write enable.
- cntrl_bits  out  3  storage channel select.
- rden  out  1  storage read strobe (rdenA).
- bdata  out  8  output byte.
- bvalid  out  1  bdata valid.
- bready  in  1  host accepts the byte when bvalid & bready.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the last byte of channel 7 is accepted.

Behaviour:
- Reset values: cap_rst=0, load=0, cntrl_bits=0, rden=0, bdata=0, bvalid=0, busy=0, done=0. FIFO empty, counters 0, state IDLE.
- Reset mid-operation: async reset clears all state immediately. No partial byte is held over.
- FSM states: IDLE, CLR, ARM, SEL, READ, DRAIN, FIN.
- IDLE: start -> CLR.
- CLR: cap_rst=1 for 2 cycles, then -> ARM.
- ARM: load=1 until _ffa samples 0. Then load drops on the next cycle, cntrl_bits=0 -> SEL.
- SEL: hold rden=0 for SWITCH_GAP cycles -> READ. Word counter cleared.
- READ: rden=1 in any cycle where (fifo_count + inflight) < BUF_DEPTH and word counter < WORDS. Each rden increments the word counter.
- In-flight tracking: inflight is an RD_LAT-deep shift register of rden. A word is pushed into the FIFO RD_LAT cycles after its rden, with no dependence on bready. The credit rule guarantees no overflow.
- READ -> DRAIN when the word counter reaches WORDS.
- DRAIN: wait until inflight=0 and the FIFO is empty. Then, if cntrl_bits<7, increment cntrl_bits -> SEL; else -> FIN.
- FIN: waits for the final byte accept, then done=1 for one cycle -> IDLE.
- Serialiser: pops a FIFO word and presents din[15:8] first, then din[7:0]. The byte advances only on bvalid&bready. bvalid, once high, holds with stable bdata until accepted.
- Simultaneous push and pop on the same cycle are both honoured; the count is unchanged.
- Channel change occurs only in DRAIN, so rden is never high in the cycle cntrl_bits changes or during the SWITCH_GAP window.
- start while busy is ignored. A _ffa glitch high after ARM is ignored.

Optional Feature:
- Macro: CAPTURE_READOUT_HEADER_EN.
- Defined: before each channel's data, emit two header bytes, 8'hA5 then {5'b0, cntrl_bits}. They are emitted in SEL via the same handshake. SEL exits only after both the header is accepted and SWITCH_GAP has elapsed. Stream length is 8*(2*WORDS+2) bytes.
- Undefined: no header; stream length is 8*2*WORDS bytes.

Test Plan:
- Reset with _rst=0 mid-READ (channel 3, word 100) -> all outputs return to reset values immediately; a new start performs a full clean readout from channel 0.
- start, _ffa falls 50 cycles after ARM entry, din=model of {ch[2:0],addr[12:0]}, bready=1, WORDS=8191 -> 131056 bytes, first bytes 8'h00,8'h00, last two 8'hFF,8'hFE, done pulses once.
- bready toggled randomly at 30% duty -> byte sequence identical to the bready=1 run; FIFO count never exceeds 4; bdata is stable while bvalid&~bready.
- Monitor each cntrl_bits transition -> rden=0 in that cycle and for the following 3 cycles; exactly 8191 rden pulses per channel.
- start asserted again while busy -> ignored; cap_rst pulses exactly once per accepted start.
- With CAPTURE_READOUT_HEADER_EN and WORDS=4 -> stream per channel is A5,0c,then 8 data bytes, for c=0..7; total 80 bytes.
